// File: rtl/collision_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// collision_pkg : shared types, defaults and address helper for the collision port
// Rev 1.0
// ---------------------------------------------------------------------------
package collision_pkg;

  localparam int              DEF_BG_W       = 500;
  localparam int              DEF_BG_H       = 500;
  localparam logic [3:0]      DEF_SOLID_CODE = 4'hF;

  typedef logic [17:0] bg_addr_t;
  typedef logic [3:0]  coll_code_t;

  // Row-major linear address; 499*500+499 = 249999 still fits in 18 bits.
  function automatic bg_addr_t xy_to_addr(input logic [8:0] x, input logic [8:0] y,
                                          input int w);
    return bg_addr_t'(32'(y) * 32'(w) + 32'(x));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : single-grant round-robin arbiter, scan starts after last winner
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          last_en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IW'((int'(r_last) + k) % N);
      if (!w_found && req[w_cand]) begin
        w_found         = 1'b1;
        grant[w_cand]   = 1'b1;
        grant_idx       = w_cand;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last <= IW'(N - 1);
    end else if (last_en) begin
      r_last <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/collision_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// collision_port_arbiter : shares the background-ROM collision port among N_REQ requesters
// Rev 1.0
// ---------------------------------------------------------------------------
module collision_port_arbiter
  import collision_pkg::*;
#(
  parameter  int         N_REQ      = 4,
  parameter  int         BG_W       = DEF_BG_W,
  parameter  int         BG_H       = DEF_BG_H,
  parameter  coll_code_t SOLID_CODE = DEF_SOLID_CODE,
  localparam int         IW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0][8:0] req_x,
  input  logic [N_REQ-1:0][8:0] req_y,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  output coll_code_t            rsp_data,
  output bg_addr_t              collision_address,
  input  coll_code_t            q_collision
);

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_idx;
  logic [8:0]       w_x;
  logic [8:0]       w_y;
  logic             w_acc;
  logic             w_oob;

  bg_addr_t         r_addr;
  logic             r_s1_vld, r_s1_oob;
  logic [IW-1:0]    r_s1_id;
  logic             r_s2_vld, r_s2_oob;
  logic [IW-1:0]    r_s2_id;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (req_valid),
    .last_en   (w_acc),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  assign req_ready = reset ? '0 : w_grant;
  assign w_acc     = |req_ready;
  assign w_x       = req_x[w_idx];
  assign w_y       = req_y[w_idx];
  assign w_oob     = (int'(w_x) >= BG_W) || (int'(w_y) >= BG_H);

  // OOB accepts leave the ROM address alone so the next in-bounds lookup is unaffected.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_s1_vld <= 1'b0;
      r_s1_oob <= 1'b0;
      r_s1_id  <= '0;
      r_s2_vld <= 1'b0;
      r_s2_oob <= 1'b0;
      r_s2_id  <= '0;
    end else begin
      if (w_acc && !w_oob) begin
        r_addr <= xy_to_addr(w_x, w_y, BG_W);
      end
      r_s1_vld <= w_acc;
      r_s1_oob <= w_oob;
      r_s1_id  <= w_idx;
      r_s2_vld <= r_s1_vld;
      r_s2_oob <= r_s1_oob;
      r_s2_id  <= r_s1_id;
    end
  end

  assign collision_address = r_addr;

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (r_s2_vld) begin
      rsp_valid[r_s2_id] = 1'b1;
      rsp_data           = r_s2_oob ? SOLID_CODE : q_collision;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_collision_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_collision_port_arbiter : table vectors + scoreboard bench with a registered ROM model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_collision_port_arbiter;

  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0][8:0] req_x = '0;
  logic [N-1:0][8:0] req_y = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [3:0]      rsp_data;
  logic [17:0]     collision_address;
  logic [3:0]      q_collision = '0;

  collision_port_arbiter #(.N_REQ(N)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_x             (req_x),
    .req_y             (req_y),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .collision_address (collision_address),
    .q_collision       (q_collision)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] rom_fn(input logic [17:0] a);
    logic [17:0] h;
    h = a ^ (a >> 5) ^ (a >> 11);
    return h[3:0] ^ 4'h5;
  endfunction

  always @(posedge clock) q_collision <= rom_fn(collision_address);

  typedef struct {
    logic [3:0]  valid;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [3:0]  exp_ready;
    logic [17:0] exp_addr;
  } vec_t;

  typedef struct {
    int         due;
    logic [3:0] oh;
    logic [3:0] data;
  } rsp_t;

  rsp_t        sb[$];
  vec_t        tbl[18];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [1:0]  m_last = 2'd3;
  logic [17:0] m_addr = '0;
  int          wait_cnt[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] rr_model(input logic [3:0] v, input logic [1:0] last);
    logic [3:0] g;
    g = '0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last) + k) % N;
      if (g == 4'b0 && v[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  task automatic run_cycle(input logic [3:0] v, input logic [N-1:0][8:0] xs,
                           input logic [N-1:0][8:0] ys, input logic [3:0] exp_ready,
                           output logic [3:0] got);
    int idx, a;
    logic oob;
    req_valid = v;
    req_x     = xs;
    req_y     = ys;
    @(negedge clock);
    got = req_ready;
    chk("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("rsp_valid", {28'd0, rsp_valid}, {28'd0, sb[0].oh});
      chk("rsp_data", {28'd0, rsp_data}, {28'd0, sb[0].data});
      void'(sb.pop_front());
    end else begin
      chk("rsp_idle_valid", {28'd0, rsp_valid}, 32'd0);
      chk("rsp_idle_data", {28'd0, rsp_data}, 32'd0);
    end
    if (exp_ready != 4'b0) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (exp_ready[i]) idx = i;
      oob = (xs[idx] >= 9'd500) || (ys[idx] >= 9'd500);
      if (!oob) begin
        a      = int'(ys[idx]) * 500 + int'(xs[idx]);
        m_addr = a[17:0];
      end
      sb.push_back('{due: cyc + 2, oh: exp_ready, data: oob ? 4'hF : rom_fn(m_addr)});
      m_last = 2'(idx);
    end
    @(posedge clock);
    #1;
    cyc++;
    chk("collision_address", {14'd0, collision_address}, {14'd0, m_addr});
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '1;
    req_x     = {4{9'd7}};
    req_y     = {4{9'd7}};
    @(negedge clock);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {28'd0, rsp_data}, 32'd0);
    chk("rst_addr", {14'd0, collision_address}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc++;
    sb.delete();
    m_last = 2'd3;
    m_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]        got;
    logic [3:0]        v;
    logic [N-1:0][8:0] xs, ys;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{4'b1111, 9'(i), 9'd1, 4'(1 << (i % 4)), 18'(500 + i)};
    tbl[8]  = '{4'b0100, 9'd10,  9'd3,   4'b0100, 18'd1510};
    tbl[9]  = '{4'b0000, 9'd0,   9'd0,   4'b0000, 18'd1510};
    tbl[10] = '{4'b0000, 9'd0,   9'd0,   4'b0000, 18'd1510};
    tbl[11] = '{4'b0010, 9'd500, 9'd0,   4'b0010, 18'd1510};
    tbl[12] = '{4'b0001, 9'd0,   9'd511, 4'b0001, 18'd1510};
    tbl[13] = '{4'b1000, 9'd499, 9'd499, 4'b1000, 18'd249999};
    tbl[14] = '{4'b1010, 9'd0,   9'd0,   4'b0010, 18'd0};
    tbl[15] = '{4'b1010, 9'd8,   9'd0,   4'b1000, 18'd8};
    tbl[16] = '{4'b0000, 9'd0,   9'd0,   4'b0000, 18'd8};
    tbl[17] = '{4'b0000, 9'd0,   9'd0,   4'b0000, 18'd8};

    @(posedge clock);
    #1;
    do_reset();

    foreach (tbl[i]) begin
      run_cycle(tbl[i].valid, {4{tbl[i].x}}, {4{tbl[i].y}}, tbl[i].exp_ready, got);
      chk("tbl_addr", {14'd0, collision_address}, {14'd0, tbl[i].exp_addr});
    end

    // Two accepts in flight, then reset lands on the cycle the first would respond.
    run_cycle(4'b0001, {4{9'd20}}, {4{9'd2}}, rr_model(4'b0001, m_last), got);
    run_cycle(4'b0010, {4{9'd21}}, {4{9'd2}}, rr_model(4'b0010, m_last), got);
    do_reset();
    for (int i = 0; i < 3; i++)
      run_cycle(4'b0000, '0, '0, 4'b0000, got);

    v = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i]  = 1'b1;
          xs[i] = 9'($urandom_range(0, 511));
          ys[i] = 9'($urandom_range(0, 511));
        end
      end
      run_cycle(v, xs, ys, rr_model(v, m_last), got);
      for (int i = 0; i < N; i++) begin
        if (v[i] && got[i]) begin
          chk("no_starve", 32'(wait_cnt[i] <= N - 1), 32'd1);
          wait_cnt[i] = 0;
          v[i]        = 1'b0;
        end else if (v[i]) begin
          wait_cnt[i]++;
        end
      end
    end

    for (int i = 0; i < 3; i++)
      run_cycle(4'b0000, '0, '0, 4'b0000, got);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
